// File: rtl/cloud_pkg.sv
// Shared encodings and widths for the background cloud scheduler.
package cloud_pkg;

    localparam int unsigned PosW = 11;
    localparam int unsigned CntW = 17;

    typedef enum logic [1:0] {
        GsInit  = 2'd0,
        GsStart = 2'd1,
        GsEnd   = 2'd2,
        GsReset = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StHold  = 2'd2,
        StClear = 2'd3
    } sched_state_e;

    // One-hot of the lowest clear bit; zero when every bit is set.
    function automatic logic [7:0] lowest_zero(input logic [7:0] v);
        return ~v & (v + 8'd1);
    endfunction

endpackage

// File: rtl/cloud_slot.sv
// One cloud slot: holds enable and x/y anchors; loads on spawn, scrolls left, retires at x == 0.
module cloud_slot
    import cloud_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic            step,
    input  logic            move,
    input  logic [PosW-1:0] load_x,
    input  logic [PosW-1:0] load_y,
    output logic            en,
    output logic [PosW-1:0] xpos,
    output logic [PosW-1:0] ypos
);

    logic            en_q, en_d;
    logic [PosW-1:0] x_q, x_d;
    logic [PosW-1:0] y_q, y_d;

    always_comb begin
        en_d = en_q;
        x_d  = x_q;
        y_d  = y_q;
        if (clr) begin
            en_d = 1'b0;
            x_d  = '0;
            y_d  = '0;
        end else if (load) begin
            en_d = 1'b1;
            x_d  = load_x;
            y_d  = load_y;
        end else if (step && en_q) begin
            // Retirement ignores the parallax gate so far clouds still leave on time.
            if (x_q == '0) begin
                en_d = 1'b0;
            end else if (move) begin
                x_d = x_q - PosW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            en_q <= en_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign en   = en_q;
    assign xpos = x_q;
    assign ypos = y_q;

endmodule

// File: rtl/cloud_scheduler.sv
// Cloud slot allocator: FSM, spawn counter and lowest-free slot selection for the background layer.
// Optional CLOUD_SCHED_PARALLAX_EN halves the scroll rate of far (high) clouds.
module cloud_scheduler
    import cloud_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = 3,
    parameter int unsigned SPAWN_INTERVAL = 50000,
    parameter int unsigned RETRY_VALUE    = 25000,
    parameter int unsigned SKIP_THRESH    = 20,
    parameter int unsigned SPAWN_X        = 692,
    parameter int unsigned CLOUD_BASE     = 240
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic [1:0]                game_state,
    input  logic [6:0]                rand_val,
    output logic [NUM_SLOTS-1:0]      cloud_en,
    output logic [PosW*NUM_SLOTS-1:0] cloud_xpos,
    output logic [PosW*NUM_SLOTS-1:0] cloud_ypos,
    output logic                      spawn_pulse
);

    localparam logic [CntW-1:0] Interval = CntW'(SPAWN_INTERVAL);
    localparam logic [CntW-1:0] Retry    = CntW'(RETRY_VALUE);

    sched_state_e    state_q, state_d;
    game_state_e     gs;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    logic                 run_tick, clr_tick, attempt, skip, alloc;
    logic [7:0]           en_pad, free_oh8;
    logic [NUM_SLOTS-1:0] free_oh, load_vec, move_vec;
    logic [PosW-1:0]      spawn_y;

    assign gs = game_state_e'(game_state);

    always_comb begin
        state_d = state_q;
        if (tick) begin
            if (gs == GsReset) begin
                state_d = StClear;
            end else if (gs == GsStart) begin
                state_d = StRun;
            end else begin
                unique case (state_q)
                    StRun:   if (gs == GsEnd) state_d = StHold;
                    StClear: state_d = StIdle;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        en_pad                  = '1;
        en_pad[NUM_SLOTS-1:0]   = cloud_en;
        free_oh8                = lowest_zero(en_pad);
        free_oh                 = free_oh8[NUM_SLOTS-1:0];
        run_tick                = tick && (state_q == StRun);
        clr_tick                = tick && (state_q == StClear);
        attempt                 = (cnt_q == Interval);
        skip                    = ({25'd0, rand_val} < SKIP_THRESH);
        alloc                   = run_tick && attempt && (|free_oh) && !skip;
        load_vec                = alloc ? free_oh : '0;
        spawn_y                 = PosW'(CLOUD_BASE) - {4'd0, rand_val};
        pulse_d                 = alloc;

        cnt_d = cnt_q;
        if (clr_tick) begin
            cnt_d = '0;
        end else if (run_tick) begin
            if (!attempt) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (!(|free_oh)) begin
                cnt_d = '0;
            end else if (skip) begin
                cnt_d = Retry;
            end else begin
                cnt_d = '0;
            end
        end
    end

`ifdef CLOUD_SCHED_PARALLAX_EN
    logic phase_q;

    // Far clouds (small y) only advance on ticks where the phase bit is set.
    always_comb begin
        move_vec = '1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            move_vec[i] = phase_q ||
                          (cloud_ypos[PosW*i +: PosW] >= PosW'(CLOUD_BASE - 64));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else if (clr_tick) begin
            phase_q <= 1'b0;
        end else if (run_tick) begin
            phase_q <= ~phase_q;
        end
    end
`else
    assign move_vec = '1;
`endif

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        cloud_slot u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr_tick),
            .load   (load_vec[i]),
            .step   (run_tick),
            .move   (move_vec[i]),
            .load_x (PosW'(SPAWN_X)),
            .load_y (spawn_y),
            .en     (cloud_en[i]),
            .xpos   (cloud_xpos[PosW*i +: PosW]),
            .ypos   (cloud_ypos[PosW*i +: PosW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign spawn_pulse = pulse_q;

endmodule

// File: tb/tb_cloud_scheduler.sv
// Randomized bench for cloud_scheduler against a slot-array reference model.
module tb_cloud_scheduler;

    localparam int NS       = 3;
    localparam int INTERVAL = 40;
    localparam int RETRY    = 20;
    localparam int SKIP     = 20;
    localparam int SPX      = 692;
    localparam int BASE     = 240;

    localparam logic [1:0] G_INIT  = 2'd0;
    localparam logic [1:0] G_START = 2'd1;
    localparam logic [1:0] G_END   = 2'd2;
    localparam logic [1:0] G_RESET = 2'd3;

    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_CLEAR = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic [1:0]        game_state = 2'd0;
    logic [6:0]        rand_val = 7'd0;
    logic [NS-1:0]     cloud_en;
    logic [11*NS-1:0]  cloud_xpos;
    logic [11*NS-1:0]  cloud_ypos;
    logic              spawn_pulse;

    int checks = 0;
    int failures = 0;

    int m_en[NS];
    int m_x[NS];
    int m_y[NS];
    int m_cnt, m_mode, m_pulse, m_phase;

    cloud_scheduler #(
        .NUM_SLOTS      (NS),
        .SPAWN_INTERVAL (INTERVAL),
        .RETRY_VALUE    (RETRY),
        .SKIP_THRESH    (SKIP),
        .SPAWN_X        (SPX),
        .CLOUD_BASE     (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .game_state  (game_state),
        .rand_val    (rand_val),
        .cloud_en    (cloud_en),
        .cloud_xpos  (cloud_xpos),
        .cloud_ypos  (cloud_ypos),
        .spawn_pulse (spawn_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_en[i] = 0;
            m_x[i]  = 0;
            m_y[i]  = 0;
        end
        m_cnt   = 0;
        m_mode  = M_IDLE;
        m_pulse = 0;
        m_phase = 0;
    endtask

    // One game tick: every decision uses the values held before the tick.
    task automatic model_tick(input int gs, input int r);
        int free;
        int alloc;
        int mv;
        alloc = 0;
        if (m_mode == M_RUN) begin
            free = -1;
            for (int i = NS - 1; i >= 0; i--) if (m_en[i] == 0) free = i;
            if (m_cnt == INTERVAL) begin
                if (free < 0)      m_cnt = 0;
                else if (r < SKIP) m_cnt = RETRY;
                else begin
                    m_cnt = 0;
                    alloc = 1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            for (int i = 0; i < NS; i++) begin
`ifdef CLOUD_SCHED_PARALLAX_EN
                mv = (m_phase != 0 || m_y[i] >= BASE - 64) ? 1 : 0;
`else
                mv = 1;
`endif
                if (alloc != 0 && i == free) begin
                    m_en[i] = 1;
                    m_x[i]  = SPX;
                    m_y[i]  = BASE - r;
                end else if (m_en[i] != 0) begin
                    if (m_x[i] == 0) m_en[i] = 0;
                    else if (mv != 0) m_x[i] = m_x[i] - 1;
                end
            end
            m_phase = 1 - m_phase;
        end else if (m_mode == M_CLEAR) begin
            for (int i = 0; i < NS; i++) begin
                m_en[i] = 0;
                m_x[i]  = 0;
                m_y[i]  = 0;
            end
            m_cnt   = 0;
            m_phase = 0;
        end
        m_pulse = alloc;
        if (gs == 3)                          m_mode = M_CLEAR;
        else if (gs == 1)                     m_mode = M_RUN;
        else if (m_mode == M_RUN && gs == 2)  m_mode = M_HOLD;
        else if (m_mode == M_CLEAR)           m_mode = M_IDLE;
    endtask

    task automatic compare_all(input string tag);
        logic [NS-1:0]    e_en;
        logic [11*NS-1:0] e_x;
        logic [11*NS-1:0] e_y;
        for (int i = 0; i < NS; i++) begin
            e_en[i]         = (m_en[i] != 0);
            e_x[11*i +: 11] = 11'(m_x[i]);
            e_y[11*i +: 11] = 11'(m_y[i]);
        end
        check_val({tag, "_en"}, 64'(cloud_en), 64'(e_en));
        check_val({tag, "_x"}, 64'(cloud_xpos), 64'(e_x));
        check_val({tag, "_y"}, 64'(cloud_ypos), 64'(e_y));
        check_val({tag, "_pulse"}, 64'(spawn_pulse), 64'(m_pulse));
    endtask

    task automatic do_tick(input logic [1:0] gs, input logic [6:0] r, input string tag);
        @(negedge clk);
        tick       = 1'b1;
        game_state = gs;
        rand_val   = r;
        model_tick(int'(gs), int'(r));
        @(posedge clk);
        #1;
        tick = 1'b0;
        compare_all(tag);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        tick     = 1'b0;
        rand_val = 7'($urandom_range(0, 127));
        m_pulse  = 0;
        @(posedge clk);
        #1;
        compare_all("gap");
    endtask

    task automatic run_ticks(input int n, input int gaps);
        logic [1:0] gs;
        for (int k = 0; k < n; k++) begin
            gs = ($urandom_range(0, 15) == 0) ? G_INIT : G_START;
            do_tick(gs, 7'($urandom_range(0, 127)), "run");
            if (gaps != 0 && $urandom_range(0, 3) == 0) idle_cycle();
        end
    endtask

    int spawns;

    always @(posedge clk) if (spawn_pulse) spawns++;

    initial begin
        spawns = 0;
        model_reset();
        #3;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) do_tick(G_INIT, 7'($urandom_range(0, 127)), "idle");
        do_tick(G_START, 7'd50, "start");
        run_ticks(1700, 1);
        check_val("spawned_some", 64'(spawns > 3), 64'd1);

        do_tick(G_END, 7'($urandom_range(0, 127)), "end");
        for (int k = 0; k < 100; k++) do_tick(G_END, 7'($urandom_range(0, 127)), "hold");
        do_tick(G_START, 7'($urandom_range(0, 127)), "resume");
        run_ticks(300, 0);

        do_tick(G_RESET, 7'($urandom_range(0, 127)), "reset_gs");
        do_tick(G_INIT, 7'($urandom_range(0, 127)), "clear");
        check_val("clear_en_zero", 64'(cloud_en), 64'd0);
        do_tick(G_INIT, 7'($urandom_range(0, 127)), "post_clear");

        do_tick(G_START, 7'($urandom_range(0, 127)), "start2");
        run_ticks(200, 1);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("arst");
        check_val("arst_en_zero", 64'(cloud_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_tick(G_START, 7'($urandom_range(0, 127)), "start3");
        run_ticks(150, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cloud_scheduler.md
# cloud_scheduler

Allocates, spawns, scrolls and retires the background cloud sprites for the dino game renderer. Owns a fixed pool of cloud slots and decides, once per game tick, whether a new cloud enters at the right edge, at what height, and which slot it occupies. Feeds per-slot enable and x/y anchor positions to the background compositor's address generators. Follows the shared `game_state` encoding.

## Interface
Parameters:
- `NUM_SLOTS`, 3, number of concurrently displayable clouds (1..8)
- `SPAWN_INTERVAL`, 50000, ticks between spawn attempts
- `RETRY_VALUE`, 25000, counter reload after a skipped attempt (< `SPAWN_INTERVAL`)
- `SKIP_THRESH`, 20, random values below this skip the spawn
- `SPAWN_X`, 692, x anchor of a fresh cloud (window width + cloud width)
- `CLOUD_BASE`, 240, y anchor = `CLOUD_BASE - rand`

Ports:
- `clk` in 1: system clock; single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `tick` in 1: one-`clk` strobe; the only event that advances state
- `game_state` in 2: 0 INIT, 1 START, 2 END, 3 RESET
- `rand` in 7: free-running random value, sampled on `tick`
- `cloud_en` out `NUM_SLOTS`: slot i visible
- `cloud_xpos` out `11*NUM_SLOTS`: slot i at bits [11i+10:11i]
- `cloud_ypos` out `11*NUM_SLOTS`: same packing
- `spawn_pulse` out 1: high one cycle when a slot is allocated

## Operation
- FSM, updated only on `tick`: IDLE (INIT) → RUN (START) → HOLD (END) → IDLE on RESET; START from any state → RUN; RESET from any state → CLEAR for one tick, then IDLE.
- CLEAR: all `cloud_en`, x, y and spawn counter to 0.
- IDLE/HOLD: positions, enables and counter frozen; no spawns.
- RUN, per tick, all evaluated from pre-tick register values:
  - Counter != `SPAWN_INTERVAL`: increment.
  - Counter == `SPAWN_INTERVAL`: if all slots enabled, counter := 0; else if `rand < SKIP_THRESH`, counter := `RETRY_VALUE`; else allocate lowest-index free slot: en := 1, x := `SPAWN_X`, y := `CLOUD_BASE - rand`, counter := 0, `spawn_pulse`.
  - Each enabled slot not being allocated this tick: x == 0 → en := 0 (x stays 0); else x := x − 1.
- A slot freed this tick is not reusable until the next attempt (allocation sees old enables).
- Widths: counter 17 bits, no wrap (saturation impossible by the compare). y: 11-bit, `rand` zero-extended; result always ≥ 113.

## Timing
- All outputs registered; update on the `clk` edge where `tick` is high, visible the next cycle.
- `spawn_pulse` high exactly one `clk` cycle, coincident with the new `cloud_en` bit.
- Reset: all outputs 0, FSM IDLE, counter 0; asserted mid-run, clears immediately (async) with no partial update.
- `tick` on consecutive `clk` cycles is legal; each is a full step.
- `game_state` sampled only with `tick`.

## Configuration
- `CLOUD_SCHED_PARALLAX_EN` defined: slots with y < `CLOUD_BASE - 64` (far clouds) move only on every second RUN tick (per-scheduler 1-bit phase toggling each RUN tick, cleared on reset/CLEAR); retirement check unchanged.
- Undefined: all slots move every RUN tick; phase register absent.

## Structure
- `cloud_pkg`: `game_state` encodings (INIT/START/END/RESET), FSM state encodings, 11-bit position width, counter width.
- Sub-module `cloud_slot`: one per slot (generate loop); holds en/x/y, implements load, decrement, retire. Scheduler keeps FSM, counter, lowest-free priority encoder.

## Test plan
- Reset, START, 50001 ticks with `rand`=50 → slot 0 en, x=692, y=190, `spawn_pulse` once; next tick x=691.
- At attempt, `rand`=5 → no spawn, counter=25000; `rand`=50 25001 ticks later → spawn in slot 0.
- Three slots full at attempt → counter resets to 0, no pulse, all x keep decrementing.
- Slot at x=0 on a tick → en drops; same-tick attempt with all others full allocates no slot; next attempt uses the freed slot.
- END mid-scroll: x frozen across 100 ticks; RESET then clears all outputs to 0; `rst_n` low mid-run clears asynchronously.
- With `CLOUD_SCHED_PARALLAX_EN`, y=120 slot moves 1 px per 2 ticks while y=200 slot moves 1 px per tick.
